// File: rtl/bp_be_irf_cfg_master_pkg.sv
// Shared types for the integer regfile cfg-port master.
// Optional full-file dump support is controlled by BP_BE_IRF_CFG_DUMP_EN.

`ifndef BP_BE_IRF_CFG_MASTER_PKG_SV
`define BP_BE_IRF_CFG_MASTER_PKG_SV

package bp_be_irf_cfg_master_pkg;

    typedef enum logic [1:0] {
        e_irf_rd   = 2'd0,
        e_irf_wr   = 2'd1,
        e_irf_dump = 2'd2
    } bp_be_irf_cfg_op_e;

    typedef enum logic [2:0] {
        e_idle     = 3'd0,
        e_rd_issue = 3'd1,
        e_rd_wait  = 3'd2,
        e_wr_issue = 3'd3,
        e_resp     = 3'd4
    } bp_be_irf_cfg_state_e;

endpackage

// Latched request: target register and write data.
`define DECLARE_BP_BE_IRF_CFG_REQ_S(dw_mp, aw_mp) \
    typedef struct packed {                         \
        logic [aw_mp-1:0] addr;                     \
        logic [dw_mp-1:0] data;                     \
    } bp_be_irf_cfg_req_s

// Held response beat presented on the resp_* outputs.
`define DECLARE_BP_BE_IRF_CFG_RESP_S(dw_mp, aw_mp) \
    typedef struct packed {                          \
        logic [aw_mp-1:0] addr;                      \
        logic [dw_mp-1:0] data;                      \
        logic             last;                      \
        logic             err;                       \
    } bp_be_irf_cfg_resp_s

`endif

// File: rtl/bp_be_irf_cfg_master.sv
// Cfg-port initiator for the integer register file: accepts read, write
// and (optionally) dump requests while the core is frozen, strobes the
// regfile cfg port and returns one response per register touched.
// Define BP_BE_IRF_CFG_DUMP_EN to enable op 2 (full-file dump); without it
// op 2 is answered as an illegal op.

module bp_be_irf_cfg_master
    import bp_be_irf_cfg_master_pkg::*;
#(
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int rd_latency_p     = 1
)
(
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        freeze_i,

    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_op_i,
    input  logic [reg_addr_width_p-1:0] req_addr_i,
    input  logic [dword_width_p-1:0]    req_data_i,

    output logic                        resp_v_o,
    input  logic                        resp_ready_i,
    output logic [reg_addr_width_p-1:0] resp_addr_o,
    output logic [dword_width_p-1:0]    resp_data_o,
    output logic                        resp_last_o,
    output logic                        resp_err_o,

    output logic                        irf_w_v_o,
    output logic                        irf_r_v_o,
    output logic [reg_addr_width_p-1:0] irf_addr_o,
    output logic [dword_width_p-1:0]    irf_data_o,
    input  logic [dword_width_p-1:0]    irf_data_i
);

    `DECLARE_BP_BE_IRF_CFG_REQ_S(dword_width_p, reg_addr_width_p);
    `DECLARE_BP_BE_IRF_CFG_RESP_S(dword_width_p, reg_addr_width_p);

    bp_be_irf_cfg_state_e state_q, state_d;
    bp_be_irf_cfg_req_s   req_q, req_d;
    bp_be_irf_cfg_resp_s  resp_q, resp_d;
    logic                 resp_en;

    logic                        req_fire;
    logic                        resp_fire;
    logic                        op_illegal;
    logic                        dump_active;
    logic                        dump_last;
    logic [reg_addr_width_p-1:0] rd_addr;

    assign req_fire  = (state_q == e_idle) && freeze_i && req_v_i && !reset_i;
    assign resp_fire = (state_q == e_resp) && resp_ready_i;

`ifdef BP_BE_IRF_CFG_DUMP_EN
    // One extra counter bit keeps the terminal compare from wrapping.
    localparam logic [reg_addr_width_p:0] last_idx_lp = {1'b0, {reg_addr_width_p{1'b1}}};

    logic                      dump_q, dump_d;
    logic [reg_addr_width_p:0] cnt_q, cnt_d;

    assign op_illegal  = (req_op_i == 2'd3);
    assign dump_active = dump_q;
    assign dump_last   = (cnt_q == last_idx_lp);
    assign rd_addr     = dump_q ? cnt_q[reg_addr_width_p-1:0] : req_q.addr;

    // Dump mode flag and register index; cleared on every accept, stepped per dump beat.
    always_comb begin
        dump_d = dump_q;
        cnt_d  = cnt_q;
        if (req_fire) begin
            dump_d = (req_op_i == e_irf_dump);
            cnt_d  = '0;
        end else if (resp_fire && dump_q && !dump_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Dump bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dump_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            dump_q <= dump_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign op_illegal  = req_op_i[1];
    assign dump_active = 1'b0;
    assign dump_last   = 1'b1;
    assign rd_addr     = req_q.addr;
`endif

    // State register and request latch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Response holding register: only loads when a new beat is formed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_q <= '0;
        end else if (resp_en) begin
            resp_q <= resp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            e_idle: begin
                if (req_fire) begin
                    if (op_illegal) begin
                        state_d = e_resp;
                    end else if (req_op_i == e_irf_wr) begin
                        state_d = e_wr_issue;
                    end else begin
                        state_d = e_rd_issue;
                    end
                end
            end
            e_rd_issue: state_d = (rd_latency_p == 0) ? e_resp : e_rd_wait;
            e_rd_wait:  state_d = e_resp;
            e_wr_issue: state_d = e_resp;
            e_resp: begin
                if (resp_fire) begin
                    state_d = (dump_active && !dump_last) ? e_rd_issue : e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Handshake and regfile strobe outputs decoded from the current state.
    always_comb begin
        req_ready_o = 1'b0;
        resp_v_o    = 1'b0;
        irf_w_v_o   = 1'b0;
        irf_r_v_o   = 1'b0;
        irf_addr_o  = '0;
        irf_data_o  = '0;
        case (state_q)
            e_idle:     req_ready_o = freeze_i && !reset_i;
            e_wr_issue: begin
                irf_w_v_o  = (req_q.addr != '0);
                irf_addr_o = req_q.addr;
                irf_data_o = req_q.data;
            end
            e_rd_issue: begin
                irf_r_v_o  = 1'b1;
                irf_addr_o = rd_addr;
            end
            e_resp:     resp_v_o = 1'b1;
            default:    ;
        endcase
    end

    // Request latch and response beat formation.
    always_comb begin
        req_d   = req_q;
        resp_en = 1'b0;
        resp_d  = '0;
        if (req_fire) begin
            req_d.addr = req_addr_i;
            req_d.data = req_data_i;
        end
        case (state_q)
            e_idle: begin
                if (req_fire && op_illegal) begin
                    resp_en     = 1'b1;
                    resp_d.addr = req_addr_i;
                    resp_d.data = '0;
                    resp_d.last = 1'b1;
                    resp_d.err  = 1'b1;
                end
            end
            e_wr_issue: begin
                resp_en     = 1'b1;
                resp_d.addr = req_q.addr;
                resp_d.data = req_q.data;
                resp_d.last = 1'b1;
                resp_d.err  = 1'b0;
            end
            e_rd_issue, e_rd_wait: begin
                if ((state_q == e_rd_wait) || (rd_latency_p == 0)) begin
                    resp_en     = 1'b1;
                    resp_d.addr = rd_addr;
                    resp_d.data = irf_data_i;
                    resp_d.last = !dump_active || dump_last;
                    resp_d.err  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign resp_addr_o = resp_q.addr;
    assign resp_data_o = resp_q.data;
    assign resp_last_o = resp_q.last;
    assign resp_err_o  = resp_q.err;

endmodule

// File: tb/tb_bp_be_irf_cfg_master.sv
// Scoreboard bench for bp_be_irf_cfg_master with a small regfile model
// (x0 reads zero, one-cycle read latency) on the cfg port.
// Exercises dump only when BP_BE_IRF_CFG_DUMP_EN is defined.

module tb_bp_be_irf_cfg_master;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
      logic        last;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        freeze_i = 1'b1;
   logic        req_v_i = 1'b0;
   logic        req_ready_o;
   logic [1:0]  req_op_i = 2'd0;
   logic [4:0]  req_addr_i = 5'd0;
   logic [63:0] req_data_i = 64'd0;
   logic        resp_v_o;
   logic        resp_ready_i = 1'b0;
   logic [4:0]  resp_addr_o;
   logic [63:0] resp_data_o;
   logic        resp_last_o;
   logic        resp_err_o;
   logic        irf_w_v_o;
   logic        irf_r_v_o;
   logic [4:0]  irf_addr_o;
   logic [63:0] irf_data_o;
   logic [63:0] irf_rdata = 64'd0;

   logic [63:0] mem [32];
   logic        loaded = 1'b0;

   exp_t        exp_q[$];
   logic [4:0]  wr_log[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          viol = 0;
   int          strobe_cnt = 0;

   logic        stall_pend = 1'b0;
   logic [4:0]  h_addr;
   logic [63:0] h_data;
   logic        h_last;
   logic        h_err;

   bp_be_irf_cfg_master dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .freeze_i     (freeze_i),
      .req_v_i      (req_v_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_addr_i   (req_addr_i),
      .req_data_i   (req_data_i),
      .resp_v_o     (resp_v_o),
      .resp_ready_i (resp_ready_i),
      .resp_addr_o  (resp_addr_o),
      .resp_data_o  (resp_data_o),
      .resp_last_o  (resp_last_o),
      .resp_err_o   (resp_err_o),
      .irf_w_v_o    (irf_w_v_o),
      .irf_r_v_o    (irf_r_v_o),
      .irf_addr_o   (irf_addr_o),
      .irf_data_o   (irf_data_o),
      .irf_data_i   (irf_rdata)
   );

   always #5 clk = ~clk;

   // Regfile model: preloaded with xi = i*0x11, x0 reads zero, registered read data.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 32; i++) mem[i] <= 64'(i) * 64'h11;
         loaded <= 1'b1;
      end else if (irf_w_v_o && irf_addr_o != 5'd0) begin
         mem[irf_addr_o] <= irf_data_o;
      end
      if (irf_r_v_o) irf_rdata <= (irf_addr_o == 5'd0) ? 64'd0 : mem[irf_addr_o];
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic pushExp(input logic [4:0] addr, input logic [63:0] data, input logic last, input logic err);
      exp_t e;
      e.addr = addr;
      e.data = data;
      e.last = last;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic pushDump(input logic [63:0] x5val);
      for (int i = 0; i < 32; i++)
         pushExp(5'(i), (i == 5) ? x5val : 64'(i) * 64'h11, (i == 31), 1'b0);
   endtask

   // Drive one request and hold it until the DUT accepts it.
   task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr, input logic [63:0] data);
      int waited = 0;
      req_op_i   = op;
      req_addr_i = addr;
      req_data_i = data;
      req_v_i    = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready_o) break;
         waited++;
         if (waited > 200) begin
            checkOutput("req_accept_timeout", 64'(waited), 64'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_v_i = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int waited = 0;
      while (exp_q.size() != 0 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({"drain_", name}, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_ctl"},
                  {48'd0, req_ready_o, resp_v_o, resp_last_o, resp_err_o,
                   irf_w_v_o, irf_r_v_o, resp_addr_o, irf_addr_o}, 64'd0);
      checkOutput({name, "_data"}, resp_data_o | irf_data_o, 64'd0);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      checkResetOutputs("abort_reset");
      exp_q.delete();
      reset_i = 1'b0;
   endtask

   // Response ready toggles randomly to exercise stalls.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         resp_ready_i = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: scoreboard compare on handshake, stall stability, strobe rules.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_i) begin
            stall_pend = 1'b0;
            continue;
         end
         if (irf_w_v_o && irf_r_v_o) viol++;
         if ((irf_w_v_o || irf_r_v_o) && (resp_v_o || req_ready_o)) viol++;
         if (irf_w_v_o) wr_log.push_back(irf_addr_o);
         if (irf_w_v_o || irf_r_v_o) strobe_cnt++;
         if (stall_pend) begin
            checkOutput("stall_stable",
                        64'(resp_v_o && resp_addr_o == h_addr && resp_data_o == h_data &&
                            resp_last_o == h_last && resp_err_o == h_err), 64'd1);
            stall_pend = 1'b0;
         end
         if (resp_v_o) begin
            if (resp_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("[TB] FAIL unexpected_resp: got addr %0d data %h, expected no response",
                           resp_addr_o, resp_data_o);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  checkOutput("resp_addr", 64'(resp_addr_o), 64'(e.addr));
                  checkOutput("resp_data", resp_data_o, e.data);
                  checkOutput("resp_last", 64'(resp_last_o), 64'(e.last));
                  checkOutput("resp_err", 64'(resp_err_o), 64'(e.err));
               end
            end else begin
               stall_pend = 1'b1;
               h_addr = resp_addr_o;
               h_data = resp_data_o;
               h_last = resp_last_o;
               h_err  = resp_err_o;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bad;
      int waited;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      reset_i = 1'b0;
      @(posedge clk);
      #1;

`ifdef BP_BE_IRF_CFG_DUMP_EN
      $display("[TB] full dump");
      pushDump(64'h22 * 64'd5 / 64'd2);
      exp_q.delete();
      pushDump(64'h55);
      applyStimulus(2'd2, 5'd9, 64'd0);
      waitDrain("dump");
`endif

      $display("[TB] write x5 then read x5");
      wr_log.delete();
      pushExp(5'd5, 64'hDEAD_BEEF, 1'b1, 1'b0);
      applyStimulus(2'd1, 5'd5, 64'hDEAD_BEEF);
      waitDrain("wr_x5");
      checkOutput("wr_x5_pulses", 64'(wr_log.size()), 64'd1);
      if (wr_log.size() > 0) checkOutput("wr_x5_addr", 64'(wr_log[0]), 64'd5);
      pushExp(5'd5, 64'hDEAD_BEEF, 1'b1, 1'b0);
      applyStimulus(2'd0, 5'd5, 64'd0);
      waitDrain("rd_x5");

      $display("[TB] write x0 suppressed");
      wr_log.delete();
      pushExp(5'd0, 64'h1234, 1'b1, 1'b0);
      applyStimulus(2'd1, 5'd0, 64'h1234);
      waitDrain("wr_x0");
      checkOutput("wr_x0_pulses", 64'(wr_log.size()), 64'd0);
      pushExp(5'd0, 64'd0, 1'b1, 1'b0);
      applyStimulus(2'd0, 5'd0, 64'hFFFF);
      waitDrain("rd_x0");

      $display("[TB] illegal op");
      strobe_cnt = 0;
      pushExp(5'd7, 64'd0, 1'b1, 1'b1);
      applyStimulus(2'd3, 5'd7, 64'hFFFF);
      waitDrain("op3");
      checkOutput("op3_strobes", 64'(strobe_cnt), 64'd0);
`ifndef BP_BE_IRF_CFG_DUMP_EN
      strobe_cnt = 0;
      pushExp(5'd9, 64'd0, 1'b1, 1'b1);
      applyStimulus(2'd2, 5'd9, 64'hABCD);
      waitDrain("op2_disabled");
      checkOutput("op2_strobes", 64'(strobe_cnt), 64'd0);
`endif

      $display("[TB] freeze gating");
      freeze_i   = 1'b0;
      req_op_i   = 2'd0;
      req_addr_i = 5'd5;
      req_data_i = 64'd0;
      req_v_i    = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_ready_o || irf_r_v_o || irf_w_v_o || resp_v_o) bad++;
      end
      checkOutput("freeze_stall", 64'(bad), 64'd0);
      pushExp(5'd5, 64'hDEAD_BEEF, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      freeze_i = 1'b1;
      @(negedge clk);
      checkOutput("freeze_ready", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      #1;
      req_v_i = 1'b0;
      waitDrain("freeze_rd");

      $display("[TB] reset abort");
`ifdef BP_BE_IRF_CFG_DUMP_EN
      pushDump(64'hDEAD_BEEF);
      applyStimulus(2'd2, 5'd0, 64'd0);
`else
      pushExp(5'd3, 64'h33, 1'b1, 1'b0);
      applyStimulus(2'd0, 5'd3, 64'd0);
`endif
      waited = 0;
      forever begin
`ifdef BP_BE_IRF_CFG_DUMP_EN
         if (irf_r_v_o && irf_addr_o == 5'd12) break;
`else
         if (irf_r_v_o) break;
`endif
         @(negedge clk);
         waited++;
         if (waited > 2000) begin
            checkOutput("abort_point_timeout", 64'(waited), 64'd0);
            break;
         end
      end
      doReset();
      pushExp(5'd3, 64'h33, 1'b1, 1'b0);
      applyStimulus(2'd0, 5'd3, 64'd0);
      waitDrain("rd_x3_after_reset");

      repeat (4) @(posedge clk);
      checkOutput("strobe_rules", 64'(viol), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bp_be_irf_cfg_master.md
Name: bp_be_irf_cfg_master

Overview:
- Configuration-side initiator for the integer register file's cfg access port (irf_w_v / irf_r_v / irf_addr / irf_data, read data returned on cfg_data).
- Accepts debug/host requests over a valid/ready interface: single read, single write, or full-file dump.
- Sequences the strobes onto the regfile cfg port, captures returned data after a fixed latency and returns responses over a valid/ready interface.
- Sits between the cfg-bus loader/debug module and bp_be_regfile; operates only while the core is frozen.

Parameters:
- dword_width_p, 64, register data width.
- reg_addr_width_p, 5, register address width; file has 2**reg_addr_width_p entries.
- rd_latency_p, 1, cycles from irf_r_v_o asserted to valid irf_data_i; legal values 0 or 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- freeze_i  in  1  core frozen; requests accepted only when high.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- req_op_i  in  2  0=read, 1=write, 2=dump, 3=illegal.
- req_addr_i  in  reg_addr_width_p  target register (ignored for dump).
- req_data_i  in  dword_width_p  write data.
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i.
- resp_addr_o  out  reg_addr_width_p  register the response refers to.
- resp_data_o  out  dword_width_p  read data; write data echoed for writes.
- resp_last_o  out  1  final response of a request (1 for read/write/error).
- resp_err_o  out  1  illegal or unsupported op.
- irf_w_v_o  out  1  regfile cfg write strobe.
- irf_r_v_o  out  1  regfile cfg read strobe.
- irf_addr_o  out  reg_addr_width_p  cfg address.
- irf_data_o  out  dword_width_p  cfg write data.
- irf_data_i  in  dword_width_p  regfile cfg read data (cfg_data).

Behaviour:
- One clock (clk_i). reset_i is synchronous and active-high.
- Reset: state=IDLE; all outputs 0; dump counter 0. Reset mid-operation aborts immediately; no response or resp_last_o is emitted for the aborted request.
- States:
  - IDLE: req_ready_o = freeze_i. On accept, latch op, addr and data.
    - read -> RD_ISSUE.
    - write -> WR_ISSUE.
    - dump -> RD_ISSUE with counter = 0.
    - illegal -> RESP with resp_err_o=1, resp_data_o=0.
  - WR_ISSUE: irf_w_v_o=1 for exactly one cycle with latched addr/data, then RESP. Writes to addr 0 are suppressed (no strobe) but still acknowledged.
  - RD_ISSUE: irf_r_v_o=1 for exactly one cycle with addr (or counter in dump).
    - rd_latency_p=0: capture irf_data_i the same cycle, go to RESP.
    - rd_latency_p=1: go to RD_WAIT, capture irf_data_i there, go to RESP.
  - RESP: resp_v_o=1; all resp_* outputs come from registers and are stable while stalled.
    - On handshake for read/write/error: go to IDLE.
    - On handshake for dump: if counter = 2**reg_addr_width_p-1, go to IDLE (resp_last_o=1 on that beat); else increment counter and go to RD_ISSUE.
- irf_w_v_o and irf_r_v_o are never high together and are never high in IDLE, RESP or RD_WAIT.
- freeze_i falling mid-request does not abort; the request completes. New requests stall until freeze_i is high again.
- req_ready_o is 0 in every state except IDLE.
- Throughput:
  - Single read: 3 cycles accept-to-resp_v_o at rd_latency_p=1, 2 cycles at 0.
  - Dump: one register per 3 cycles (2 at rd_latency_p=0) with resp_ready_i held high.
- Counter is reg_addr_width_p+1 bits so the terminal compare does not wrap; counter is cleared on dump accept.

Optional Feature:
- Macro BP_BE_IRF_CFG_DUMP_EN.
- Defined: op 2 performs a full-file dump as above.
- Undefined: dump logic and counter are removed; op 2 is treated as illegal (single response, resp_err_o=1, resp_last_o=1, no irf strobes).

Decomposition:
- Shared package (bp_be pkg): enum bp_be_irf_cfg_op_e {e_irf_rd=0, e_irf_wr=1, e_irf_dump=2}; FSM state enum; request and response struct typedefs parameterized by dword_width_p/reg_addr_width_p via declare macro.
- No sub-module; counter and FSM are inline. Response holding uses a bsg_dff_en-style register.

Test Plan:
- freeze_i=1, write x5=0xDEAD_BEEF, then read x5 -> one irf_w_v_o pulse with addr=5; read response resp_data_o=0xDEADBEEF, resp_addr_o=5, resp_last_o=1.
- Write x0=0x1234 -> no irf_w_v_o pulse; response echoes 0x1234, resp_err_o=0.
- Dump with regfile preloaded xi=i*0x11, resp_ready_i random 50% -> 32 responses, addrs 0..31 in order, data i*0x11, resp_last_o only on addr 31, outputs stable while stalled.
- req_op_i=3 -> single response with resp_err_o=1, data 0, no irf strobes. Without BP_BE_IRF_CFG_DUMP_EN, op 2 gives the same result.
- req_v_i=1 with freeze_i=0 for 10 cycles -> req_ready_o=0, no strobes. Raise freeze_i -> accepted the next cycle.
- Assert reset_i during dump at addr 12 -> next cycle all outputs 0, state IDLE. A fresh read of x3 then completes normally.
